wb_dest_queue: RTL and testbench

//  Write-back destination queue for the register bank. It resolves the destination

---
 rtl/wb_dest_queue_if.sv | 33 +++
 rtl/wb_dest_queue.sv | 115 +++++++++++
 tb/tb_wb_dest_queue.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/wb_dest_queue_if.sv
// Bus bundle between the result path (master) and the write-back destination queue (slave).
// Carries the request handshake, queue controls and the register bank write port.
interface wb_dest_queue_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        Select;
  logic [ADDR_W-1:0] I0;
  logic [15:0]       I1;
  logic [DATA_W-1:0] req_data;
  logic              flush;
  logic              wr_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  count;
  logic              dropped;

  modport master (
    output req_valid, Select, I0, I1, req_data, flush, wr_stall,
    input  req_ready, wr_en, wr_addr, wr_data, count, dropped
  );

  modport slave (
    input  req_valid, Select, I0, I1, req_data, flush, wr_stall,
    output req_ready, wr_en, wr_addr, wr_data, count, dropped
  );
endinterface

// File: rtl/wb_dest_queue.sv
// Write-back destination queue: resolves the destination register index and buffers
// {index, data} writes in a small FIFO drained one entry per cycle into the register bank.
module wb_dest_queue #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int SP_REG    = 29,
  parameter int RA_REG    = 31,
  parameter int RD_LSB    = 11,
  parameter int DROP_ZERO = 1
) (
  input logic             clk,
  input logic             reset_n,
  wb_dest_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};

  function automatic logic [ADDR_W-1:0] f_resolve_idx(
    input logic [1:0]        sel,
    input logic [ADDR_W-1:0] i0,
    input logic [15:0]       i1
  );
    logic [ADDR_W-1:0] idx;
    case (sel)
      2'b00:   idx = i0;
      2'b01:   idx = ADDR_W'(i1 >> RD_LSB);
      2'b10:   idx = ADDR_W'(SP_REG);
      2'b11:   idx = ADDR_W'(RA_REG);
      default: idx = IDX_ZERO;
    endcase
    return idx;
  endfunction

  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_dropped;

  logic [ADDR_W-1:0] w_idx;
  logic              w_accept;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_nonempty;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;

  assign w_idx      = f_resolve_idx(bus.Select, bus.I0, bus.I1);
  assign w_nonempty = (r_count != CNT_ZERO);
  // Ready looks only at the stored count so wr_stall never reaches req_ready.
  assign bus.req_ready = (r_count < CNT_FULL);
  assign w_accept   = bus.req_valid & bus.req_ready;
  assign w_drop     = w_accept & (DROP_ZERO != 0) & (w_idx == IDX_ZERO) & ~bus.flush;
  assign w_push     = w_accept & ~w_drop & ~bus.flush;
  assign w_pop      = w_nonempty & ~bus.wr_stall & ~bus.flush;

  // Head entry presented to the register bank; zero when the queue is empty.
  always_comb begin
    w_wr_addr = IDX_ZERO;
    w_wr_data = {DATA_W{1'b0}};
    if (w_nonempty) begin
      w_wr_addr = r_mem_addr[r_rptr];
      w_wr_data = r_mem_data[r_rptr];
    end else begin
      w_wr_addr = IDX_ZERO;
      w_wr_data = {DATA_W{1'b0}};
    end
  end

  // FIFO storage, pointers, occupancy and drop pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr    <= {PTR_W{1'b0}};
      r_rptr    <= {PTR_W{1'b0}};
      r_count   <= CNT_ZERO;
      r_dropped <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_addr[i] <= IDX_ZERO;
        r_mem_data[i] <= {DATA_W{1'b0}};
      end
    end else if (bus.flush) begin
      r_wptr    <= {PTR_W{1'b0}};
      r_rptr    <= {PTR_W{1'b0}};
      r_count   <= CNT_ZERO;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= w_drop;
      if (w_push) begin
        r_mem_addr[r_wptr] <= w_idx;
        r_mem_data[r_wptr] <= bus.req_data;
        r_wptr             <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.wr_en   = w_pop;
  assign bus.wr_addr = w_wr_addr;
  assign bus.wr_data = w_wr_data;
  assign bus.count   = r_count;
  assign bus.dropped = r_dropped;
endmodule

// File: tb/tb_wb_dest_queue.sv
// Directed bench for wb_dest_queue: index resolution, FIFO order, stall/full,
// drop of index 0, flush and asynchronous reset mid-drain.
module tb_wb_dest_queue;
  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_pass;

  wb_dest_queue_if #(.ADDR_W(5), .DATA_W(32), .DEPTH(4)) bus ();

  wb_dest_queue #(
    .ADDR_W(5), .DATA_W(32), .DEPTH(4), .SP_REG(29), .RA_REG(31),
    .RD_LSB(11), .DROP_ZERO(1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] sel, input logic [4:0] i0,
                           input logic [15:0] i1, input logic [31:0] data);
    bus.req_valid = 1'b1;
    bus.Select    = sel;
    bus.I0        = i0;
    bus.I1        = i1;
    bus.req_data  = data;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.Select    = 2'b00;
    bus.I0        = 5'd0;
    bus.I1        = 16'h0000;
    bus.req_data  = 32'h0;
    bus.flush     = 1'b0;
    bus.wr_stall  = 1'b0;

    // Reset state
    #3;
    check_eq("rst_wr_en",   64'(bus.wr_en),   64'd0);
    check_eq("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
    check_eq("rst_wr_data", 64'(bus.wr_data), 64'd0);
    check_eq("rst_count",   64'(bus.count),   64'd0);
    check_eq("rst_dropped", 64'(bus.dropped), 64'd0);
    #9;
    reset_n = 1'b1;
    #1;
    check_eq("rst_ready", 64'(bus.req_ready), 64'd1);
    tick();

    // Single write via I0, one-cycle latency
    drive_req(2'b00, 5'd8, 16'h0000, 32'hA5A5_0001);
    tick();
    bus.req_valid = 1'b0;
    check_eq("t1_count1",  64'(bus.count),   64'd1);
    check_eq("t1_wr_en",   64'(bus.wr_en),   64'd1);
    check_eq("t1_wr_addr", 64'(bus.wr_addr), 64'd8);
    check_eq("t1_wr_data", 64'(bus.wr_data), 64'hA5A5_0001);
    tick();
    check_eq("t1_count0",  64'(bus.count),   64'd0);
    check_eq("t1_idle_en", 64'(bus.wr_en),   64'd0);
    check_eq("t1_idle_ad", 64'(bus.wr_addr), 64'd0);

    // rd, SP and RA selections in enqueue order
    drive_req(2'b01, 5'd3, 16'h5800, 32'h0000_0011);
    tick();
    check_eq("t2_rd_addr", 64'(bus.wr_addr), 64'd11);
    drive_req(2'b10, 5'd3, 16'h5800, 32'h0000_0029);
    tick();
    check_eq("t2_sp_addr", 64'(bus.wr_addr), 64'd29);
    check_eq("t2_sp_data", 64'(bus.wr_data), 64'h0000_0029);
    check_eq("t2_count",   64'(bus.count),   64'd1);
    drive_req(2'b11, 5'd3, 16'h5800, 32'h0000_0031);
    tick();
    bus.req_valid = 1'b0;
    check_eq("t2_ra_addr", 64'(bus.wr_addr), 64'd31);
    check_eq("t2_ra_data", 64'(bus.wr_data), 64'h0000_0031);
    tick();
    check_eq("t2_count0",  64'(bus.count),   64'd0);

    // Stall with five back-to-back requests; the fifth is refused
    bus.wr_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_req(2'b00, 5'(i + 1), 16'h0000, 32'(100 + i));
      #1;
      check_eq($sformatf("t3_ready%0d", i), 64'(bus.req_ready), (i < 4) ? 64'd1 : 64'd0);
      tick();
    end
    check_eq("t3_full_cnt", 64'(bus.count),     64'd4);
    check_eq("t3_full_rdy", 64'(bus.req_ready), 64'd0);
    check_eq("t3_stall_en", 64'(bus.wr_en),     64'd0);
    check_eq("t3_hold_ad",  64'(bus.wr_addr),   64'd1);
    bus.req_valid = 1'b0;
    bus.wr_stall  = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("t3_en%0d", k),   64'(bus.wr_en),   64'd1);
      check_eq($sformatf("t3_addr%0d", k), 64'(bus.wr_addr), 64'(k + 1));
      check_eq($sformatf("t3_data%0d", k), 64'(bus.wr_data), 64'(100 + k));
      check_eq($sformatf("t3_cnt%0d", k),  64'(bus.count),   64'(4 - k));
      tick();
    end
    check_eq("t3_empty_cnt", 64'(bus.count), 64'd0);
    check_eq("t3_empty_en",  64'(bus.wr_en), 64'd0);

    // Index 0 is dropped with a one-cycle pulse
    drive_req(2'b00, 5'd0, 16'h0000, 32'hDEAD_0000);
    tick();
    bus.req_valid = 1'b0;
    check_eq("t4_dropped", 64'(bus.dropped), 64'd1);
    check_eq("t4_count",   64'(bus.count),   64'd0);
    check_eq("t4_wr_en",   64'(bus.wr_en),   64'd0);
    tick();
    check_eq("t4_pulse",   64'(bus.dropped), 64'd0);

    // Flush with a same-cycle request
    bus.wr_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_req(2'b00, 5'(i + 3), 16'h0000, 32'(200 + i));
      tick();
    end
    check_eq("t5_count3", 64'(bus.count), 64'd3);
    bus.wr_stall = 1'b0;
    bus.flush    = 1'b1;
    drive_req(2'b00, 5'd7, 16'h0000, 32'h7777_7777);
    #1;
    check_eq("t5_flush_en", 64'(bus.wr_en), 64'd0);
    tick();
    check_eq("t5_count0", 64'(bus.count),   64'd0);
    check_eq("t5_en_post", 64'(bus.wr_en),  64'd0);
    drive_req(2'b00, 5'd0, 16'h0000, 32'h0);
    tick();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    check_eq("t5_no_drop", 64'(bus.dropped), 64'd0);
    check_eq("t5_count_z", 64'(bus.count),   64'd0);

    // Asynchronous reset while draining
    bus.wr_stall = 1'b1;
    drive_req(2'b00, 5'd9, 16'h0000, 32'h9);
    tick();
    drive_req(2'b00, 5'd10, 16'h0000, 32'hA);
    tick();
    bus.req_valid = 1'b0;
    bus.wr_stall  = 1'b0;
    #1;
    check_eq("t6_pre_en",  64'(bus.wr_en), 64'd1);
    check_eq("t6_pre_cnt", 64'(bus.count), 64'd2);
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_en",  64'(bus.wr_en),   64'd0);
    check_eq("t6_rst_cnt", 64'(bus.count),   64'd0);
    check_eq("t6_rst_ad",  64'(bus.wr_addr), 64'd0);
    tick();
    tick();
    #2;
    reset_n = 1'b1;
    #1;
    check_eq("t6_ready", 64'(bus.req_ready), 64'd1);
    tick();
    check_eq("t6_post_en",  64'(bus.wr_en), 64'd0);
    check_eq("t6_post_cnt", 64'(bus.count), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
